ipml_prefetch_fifo_sync_v2_0: RTL and testbench

//  - Single-clock first-word-fall-through FIFO: inferred RAM (1-cycle read latency) plus a 2-entry output skid buffer kept full by prefetch.
//  - Adds to the previous prefetch FIFO: synchronous flush, total occupancy count, and almost-full/almost-empty flags with parameterised thresholds.
//  - Used on single-clock AXI address/command paths in the video pipeline in place of the dual-clock prefetch FIFO.

---
 rtl/ipml_prefetch_fifo_sync_v2_0_if.sv | 28 ++
 rtl/ipml_prefetch_fifo_sync_v2_0.sv | 160 ++++++++++++++++
 tb/tb_ipml_prefetch_fifo_sync_v2_0.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ipml_prefetch_fifo_sync_v2_0_if.sv
// Handshake bundle for ipml_prefetch_fifo_sync_v2_0.
// master: the side that writes/reads the FIFO; slave: the FIFO itself.
interface ipml_prefetch_fifo_sync_v2_0_if #(
  parameter int unsigned c_DATA_WIDTH  = 32,
  parameter int unsigned c_DEPTH_WIDTH = 10
);
  logic                    flush;
  logic [c_DATA_WIDTH-1:0] wr_data;
  logic                    wr_en;
  logic                    wr_vld;
  logic                    almost_full;
  logic [c_DATA_WIDTH-1:0] rd_data;
  logic                    rd_en;
  logic                    rd_vld;
  logic                    almost_empty;
  logic [c_DEPTH_WIDTH:0]  water_level;
  logic                    rd_par_err;

  modport master (
    output flush, wr_data, wr_en, rd_en,
    input  wr_vld, almost_full, rd_data, rd_vld, almost_empty, water_level, rd_par_err
  );

  modport slave (
    input  flush, wr_data, wr_en, rd_en,
    output wr_vld, almost_full, rd_data, rd_vld, almost_empty, water_level, rd_par_err
  );
endinterface

// File: rtl/ipml_prefetch_fifo_sync_v2_0.sv
// Single-clock first-word-fall-through FIFO: inferred RAM with 1-cycle read latency followed by
// a 2-entry skid buffer that is kept full by prefetching. Adds synchronous flush, a total
// occupancy count (RAM + in-flight read + skid) and almost-full/almost-empty flags.
// Optional feature: define IPML_PREFETCH_FIFO_PARITY_EN to store an even-parity bit per word
// and report a mismatch on the head word through rd_par_err.
module ipml_prefetch_fifo_sync_v2_0 #(
  parameter int unsigned c_DATA_WIDTH  = 32,
  parameter int unsigned c_DEPTH_WIDTH = 10,
  parameter int unsigned c_AF_LEVEL    = 1020,
  parameter int unsigned c_AE_LEVEL    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  ipml_prefetch_fifo_sync_v2_0_if.slave  fifo_if
);

  localparam int unsigned Depth = 2 ** c_DEPTH_WIDTH;
  localparam int unsigned LvlW  = c_DEPTH_WIDTH + 1;
`ifdef IPML_PREFETCH_FIFO_PARITY_EN
  localparam int unsigned RamWidth = c_DATA_WIDTH + 1;
`else
  localparam int unsigned RamWidth = c_DATA_WIDTH;
`endif

  logic [c_DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]          ram_cnt_q, ram_cnt_d;
  logic [LvlW-1:0]          level_q, level_d;
  logic                     wr_vld_q, wr_vld_d;
  logic                     af_q, af_d;
  logic                     ae_q, ae_d;
  logic                     inflight_q, inflight_d;
  logic [1:0]               skid_cnt_q, skid_cnt_d;
  logic [RamWidth-1:0]      skid0_q, skid0_d;
  logic [RamWidth-1:0]      skid1_q, skid1_d;
  logic [RamWidth-1:0]      ram_rd_q;
  logic [RamWidth-1:0]      mem_q [Depth];

  logic                     rd_vld;
  logic                     push;
  logic                     pop;
  logic                     issue;
  logic [RamWidth-1:0]      wr_word;

  assign rd_vld = (skid_cnt_q != 2'd0);
  // Requests coinciding with flush are discarded.
  assign push   = fifo_if.wr_en & wr_vld_q & ~fifo_if.flush;
  assign pop    = fifo_if.rd_en & rd_vld & ~fifo_if.flush;
  // Keep skid + in-flight at 2; a pop frees one slot in the same cycle.
  assign issue  = ~fifo_if.flush & (ram_cnt_q != '0) &
                  ((({1'b0, skid_cnt_q} + {2'b00, inflight_q}) < 3'd2) | pop);

`ifdef IPML_PREFETCH_FIFO_PARITY_EN
  assign wr_word            = {^fifo_if.wr_data, fifo_if.wr_data};
  assign fifo_if.rd_par_err = rd_vld & (skid0_q[c_DATA_WIDTH] != ^skid0_q[c_DATA_WIDTH-1:0]);
`else
  assign wr_word            = fifo_if.wr_data;
  assign fifo_if.rd_par_err = 1'b0;
`endif

  assign fifo_if.rd_data      = skid0_q[c_DATA_WIDTH-1:0];
  assign fifo_if.rd_vld       = rd_vld;
  assign fifo_if.wr_vld       = wr_vld_q;
  assign fifo_if.almost_full  = af_q;
  assign fifo_if.almost_empty = ae_q;
  assign fifo_if.water_level  = level_q;

  // RAM storage and its registered read port; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
    if (issue) begin
      ram_rd_q <= mem_q[rd_ptr_q];
    end
  end

  // Next-state for pointers, counts, flags and the skid buffer.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    level_d    = level_q;
    wr_vld_d   = wr_vld_q;
    af_d       = af_q;
    ae_d       = ae_q;
    inflight_d = 1'b0;
    skid_cnt_d = skid_cnt_q;
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    if (fifo_if.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ram_cnt_d  = '0;
      level_d    = '0;
      wr_vld_d   = 1'b1;
      af_d       = 1'b0;
      ae_d       = 1'b1;
      skid_cnt_d = 2'd0;
      skid0_d    = '0;
      skid1_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (issue) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      ram_cnt_d  = ram_cnt_q + {{c_DEPTH_WIDTH{1'b0}}, push} - {{c_DEPTH_WIDTH{1'b0}}, issue};
      level_d    = level_q + {{c_DEPTH_WIDTH{1'b0}}, push} - {{c_DEPTH_WIDTH{1'b0}}, pop};
      inflight_d = issue;
      wr_vld_d   = 32'(ram_cnt_d) < Depth;
      af_d       = 32'(level_d) >= c_AF_LEVEL;
      ae_d       = 32'(level_d) <= c_AE_LEVEL;
      // Pop shifts the second entry to the head, then the landing RAM word fills the tail.
      if (pop) begin
        skid0_d    = skid1_q;
        skid_cnt_d = skid_cnt_d - 1'b1;
      end
      if (inflight_q) begin
        if (skid_cnt_d == 2'd0) begin
          skid0_d = ram_rd_q;
        end else begin
          skid1_d = ram_rd_q;
        end
        skid_cnt_d = skid_cnt_d + 1'b1;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      level_q    <= '0;
      wr_vld_q   <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      inflight_q <= 1'b0;
      skid_cnt_q <= 2'd0;
      skid0_q    <= '0;
      skid1_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      level_q    <= level_d;
      wr_vld_q   <= wr_vld_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      inflight_q <= inflight_d;
      skid_cnt_q <= skid_cnt_d;
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
    end
  end

endmodule

// File: tb/tb_ipml_prefetch_fifo_sync_v2_0.sv
// Directed bench for ipml_prefetch_fifo_sync_v2_0 with a 4-deep RAM (capacity 6).
module tb_ipml_prefetch_fifo_sync_v2_0;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ipml_prefetch_fifo_sync_v2_0_if #(.c_DATA_WIDTH(DW), .c_DEPTH_WIDTH(AW)) fifo_if ();

  ipml_prefetch_fifo_sync_v2_0 #(
    .c_DATA_WIDTH (DW),
    .c_DEPTH_WIDTH(AW),
    .c_AF_LEVEL   (5),
    .c_AE_LEVEL   (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .fifo_if(fifo_if)
  );

  typedef struct {
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic          wr_vld;
    logic          rd_vld;
    logic [DW-1:0] rd_data;
    logic [AW:0]   wl;
    logic          af;
    logic          ae;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fl, input logic we, input logic [DW-1:0] wd, input logic re);
    fifo_if.flush   = fl;
    fifo_if.wr_en   = we;
    fifo_if.wr_data = wd;
    fifo_if.rd_en   = re;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr_vld"}, 32'(fifo_if.wr_vld), 32'd1);
    check({tag, "_rd_vld"}, 32'(fifo_if.rd_vld), 32'd0);
    check({tag, "_af"}, 32'(fifo_if.almost_full), 32'd0);
    check({tag, "_ae"}, 32'(fifo_if.almost_empty), 32'd1);
    check({tag, "_wl"}, 32'(fifo_if.water_level), 32'd0);
    check({tag, "_par"}, 32'(fifo_if.rd_par_err), 32'd0);
    check({tag, "_rd_data"}, 32'(fifo_if.rd_data), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] nxt;
    logic [DW-1:0] exp_head;
    int            bub;
    int            derr;
    int            lerr;
    logic          exp_par;

    // fl we data re | wr_vld rd_vld rd_data wl af ae
    vecs[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h11, 3'd4, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 8'h11, 3'd5, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 8'h11, 3'd6, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'h11, 3'd6, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 3'd5, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 3'd4, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 3'd3, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h55, 3'd2, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h66, 3'd1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
    // push+pop with only one word held: rd_vld gap then the new word appears
    vecs[14] = '{1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h81, 3'd1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 8'h82, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h82, 3'd1, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};

    drive(1'b0, 1'b0, '0, 1'b0);
    #12;
    check_reset_vals("reset");
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].flush, vecs[i].wr_en, vecs[i].wr_data, vecs[i].rd_en);
      tick();
      check($sformatf("v%0d_wr_vld", i), 32'(fifo_if.wr_vld), 32'(vecs[i].wr_vld));
      check($sformatf("v%0d_rd_vld", i), 32'(fifo_if.rd_vld), 32'(vecs[i].rd_vld));
      if (vecs[i].rd_vld) begin
        check($sformatf("v%0d_rd_data", i), 32'(fifo_if.rd_data), 32'(vecs[i].rd_data));
      end
      check($sformatf("v%0d_wl", i), 32'(fifo_if.water_level), 32'(vecs[i].wl));
      check($sformatf("v%0d_af", i), 32'(fifo_if.almost_full), 32'(vecs[i].af));
      check($sformatf("v%0d_ae", i), 32'(fifo_if.almost_empty), 32'(vecs[i].ae));
      check($sformatf("v%0d_par", i), 32'(fifo_if.rd_par_err), 32'd0);
    end

    // Continuous push+pop at water_level 3.
    nxt = 8'hC0;
    exp_head = 8'hC0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, nxt, 1'b0);
      tick();
      nxt++;
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    tick();
    check("stream_start_wl", 32'(fifo_if.water_level), 32'd3);
    bub = 0;
    derr = 0;
    lerr = 0;
    for (int i = 0; i < 1000; i++) begin
      if (fifo_if.rd_vld !== 1'b1 || fifo_if.wr_vld !== 1'b1) bub++;
      if (fifo_if.rd_data !== exp_head) derr++;
      drive(1'b0, 1'b1, nxt, 1'b1);
      tick();
      nxt++;
      exp_head++;
      if (fifo_if.water_level !== 3'd3) lerr++;
    end
    check("stream_bubbles", 32'(bub), 32'd0);
    check("stream_data_errs", 32'(derr), 32'd0);
    check("stream_level_errs", 32'(lerr), 32'd0);
    check("stream_end_head", 32'(fifo_if.rd_data), 32'(exp_head));

    // Flush at water_level 5 with a concurrent push and pop.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, nxt, 1'b0);
      tick();
      nxt++;
    end
    check("pre_flush_wl", 32'(fifo_if.water_level), 32'd5);
    check("pre_flush_af", 32'(fifo_if.almost_full), 32'd1);
    drive(1'b1, 1'b1, 8'hEE, 1'b1);
    tick();
    check_reset_vals("flush");
    drive(1'b0, 1'b1, 8'hBB, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    check("post_flush_wl", 32'(fifo_if.water_level), 32'd1);
    check("post_flush_rv_t1", 32'(fifo_if.rd_vld), 32'd0);
    tick();
    check("post_flush_rv_t2", 32'(fifo_if.rd_vld), 32'd0);
    tick();
    check("post_flush_rv_t3", 32'(fifo_if.rd_vld), 32'd1);
    check("post_flush_data", 32'(fifo_if.rd_data), 32'hBB);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'(8'h01 + i), 1'b0);
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b1, 8'h5A, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    tick();
    check("after_rst_rv_t2", 32'(fifo_if.rd_vld), 32'd0);
    tick();
    check("after_rst_rv_t3", 32'(fifo_if.rd_vld), 32'd1);
    check("after_rst_data", 32'(fifo_if.rd_data), 32'h5A);
    check("after_rst_wl", 32'(fifo_if.water_level), 32'd1);

    // Parity: corrupt the stored parity of 0xA5 while it sits in RAM.
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    drive(1'b0, 1'b1, 8'h3C, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'hA5, 1'b0);
    tick();
`ifdef IPML_PREFETCH_FIFO_PARITY_EN
    dut.mem_q[1][DW] = ~dut.mem_q[1][DW];
    exp_par = 1'b1;
`else
    exp_par = 1'b0;
`endif
    drive(1'b0, 1'b1, 8'h5A, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    tick();
    check("par_head0_data", 32'(fifo_if.rd_data), 32'h3C);
    check("par_head0_err", 32'(fifo_if.rd_par_err), 32'd0);
    drive(1'b0, 1'b0, '0, 1'b1);
    tick();
    check("par_head1_data", 32'(fifo_if.rd_data), 32'hA5);
    check("par_head1_err", 32'(fifo_if.rd_par_err), 32'(exp_par));
    tick();
    check("par_head2_data", 32'(fifo_if.rd_data), 32'h5A);
    check("par_head2_err", 32'(fifo_if.rd_par_err), 32'd0);
    tick();
    check("par_empty_rv", 32'(fifo_if.rd_vld), 32'd0);
    check("par_empty_err", 32'(fifo_if.rd_par_err), 32'd0);
    drive(1'b0, 1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
